// File: rtl/mips16_pkg.sv
// Shared encodings for the mips16 sequencer and datapath: opcodes, states, ALU ops, mux selects.
package mips16_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADDI = 3'b001,
        OP_NAND = 3'b010,
        OP_LUI  = 3'b011,
        OP_SW   = 3'b100,
        OP_LW   = 3'b101,
        OP_BNE  = 3'b110,
        OP_JALR = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERROR  = 3'd7
    } state_t;

    typedef logic [3:0] alu_op_t;
    localparam alu_op_t ALU_ADD  = 4'b0000;
    localparam alu_op_t ALU_ADDI = 4'b0001;
    localparam alu_op_t ALU_NAND = 4'b0010;
    localparam alu_op_t ALU_LUI  = 4'b0011;
    localparam alu_op_t ALU_SWA  = 4'b0100;
    localparam alu_op_t ALU_LWA  = 4'b0101;
    localparam alu_op_t ALU_SUB  = 4'b0110;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_REG = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    function automatic alu_op_t alu_op_of(opcode_t op);
        case (op)
            OP_ADDI: return ALU_ADDI;
            OP_NAND: return ALU_NAND;
            OP_LUI:  return ALU_LUI;
            OP_SW:   return ALU_SWA;
            OP_LW:   return ALU_LWA;
            OP_BNE:  return ALU_SUB;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic alu_src_of(opcode_t op);
        return (op == OP_ADDI) || (op == OP_LUI) || (op == OP_SW) || (op == OP_LW);
    endfunction

endpackage

// File: rtl/mips16_seq_ctrl_mem_wait_timer.sv
// Counts unacknowledged memory request cycles; expired marks the last cycle an ack may still arrive.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/mips16_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory watchdog and retire counter.
module mips16_seq_ctrl
    import mips16_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [2:0]       opcode,
    input  logic             alu_zero,
    input  logic             mem_ack,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             reg_we,
    output logic [1:0]       wb_src,
    output logic [3:0]       alu_op,
    output logic             alu_src,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count,
    output logic             bus_err
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             bus_err_q;
    logic             retire, tmr_en, tmr_exp;
    opcode_t          op;

    assign op = opcode_t'(opcode);

    // Any state change clears the timer, which covers every entry into FETCH and MEM.
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_d != state_q),
        .en      (tmr_en),
        .expired (tmr_exp)
    );

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        tmr_en  = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_src  = PC_INC;
        reg_we  = 1'b0;
        wb_src  = WB_ALU;
        alu_op  = ALU_ADD;
        alu_src = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        mem_sel = 1'b0;
        case (state_q)
            ST_IDLE: if (run) state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (tmr_exp) state_d = ST_ERROR;
                else                  tmr_en  = 1'b1;
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                alu_op  = alu_op_of(op);
                alu_src = alu_src_of(op);
                case (op)
                    OP_SW, OP_LW: state_d = ST_MEM;
                    OP_BNE: begin
                        pc_we  = !alu_zero;
                        pc_src = PC_BR;
                        retire = 1'b1;
                    end
                    OP_JALR: begin
                        reg_we = 1'b1;
                        wb_src = WB_PC;
                        pc_we  = 1'b1;
                        pc_src = PC_REG;
                        retire = 1'b1;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = (op == OP_SW);
                alu_op  = alu_op_of(op);
                alu_src = alu_src_of(op);
                if (mem_ack) begin
                    if (op == OP_SW) retire  = 1'b1;
                    else             state_d = ST_WB;
                end else if (tmr_exp) state_d = ST_ERROR;
                else                  tmr_en  = 1'b1;
            end
            ST_WB: begin
                reg_we  = 1'b1;
                wb_src  = (op == OP_LW) ? WB_MEM : WB_ALU;
                alu_op  = alu_op_of(op);
                alu_src = alu_src_of(op);
                retire  = 1'b1;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
        endcase
        if (retire) state_d = run ? ST_FETCH : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire)              cnt_q     <= cnt_q + 1'b1;
            if (state_d == ST_ERROR) bus_err_q <= 1'b1;
        end
    end

    assign state       = state_q;
    assign instr_count = cnt_q;
    assign bus_err     = bus_err_q;
endmodule

// File: tb/tb_mips16_seq_ctrl.sv
// Directed bench for mips16_seq_ctrl with a short watchdog (MEM_TIMEOUT=4).
module tb_mips16_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst, run, alu_zero, mem_ack;
    logic [2:0]  opcode;
    logic        ir_we, pc_we, reg_we, alu_src, mem_req, mem_we, mem_sel, bus_err;
    logic [1:0]  pc_src, wb_src;
    logic [3:0]  alu_op;
    logic [2:0]  state;
    logic [15:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips16_seq_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ack(mem_ack), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .reg_we(reg_we), .wb_src(wb_src), .alu_op(alu_op), .alu_src(alu_src),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .state(state),
        .instr_count(instr_count), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    // Fetch with immediate ack, then DECODE; leaves the bench in EXEC after the second edge.
    task automatic fetch_to_exec(input logic [2:0] op);
        opcode  = op;
        mem_ack = 1'b1;
        go();
        mem_ack = 1'b0;
        go();
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; opcode = 3'b000; alu_zero = 1'b0; mem_ack = 1'b0;
        go(); go();
        chk("rst_state", state, 0);
        chk("rst_cnt", instr_count, 0);
        chk("rst_buserr", bus_err, 0);
        chk("rst_memreq", mem_req, 0);
        chk("rst_aluop", alu_op, 0);
        rst = 1'b0;
        go();
        chk("idle_hold", state, 0);

        // ADDI: 1,2,3,5
        run = 1'b1;
        go();
        opcode = 3'b001; mem_ack = 1'b1; #1;
        chk("addi_f_state", state, 1);
        chk("addi_f_req", mem_req, 1);
        chk("addi_f_sel", mem_sel, 0);
        chk("addi_f_irwe", ir_we, 1);
        chk("addi_f_pcwe", pc_we, 1);
        chk("addi_f_pcsrc", pc_src, 0);
        go(); mem_ack = 1'b0; #1;
        chk("addi_d_state", state, 2);
        chk("addi_d_req", mem_req, 0);
        chk("addi_d_pcwe", pc_we, 0);
        chk("addi_d_irwe", ir_we, 0);
        go();
        chk("addi_e_state", state, 3);
        chk("addi_e_aluop", alu_op, 1);
        chk("addi_e_alusrc", alu_src, 1);
        chk("addi_e_regwe", reg_we, 0);
        go();
        chk("addi_w_state", state, 5);
        chk("addi_w_regwe", reg_we, 1);
        chk("addi_w_wbsrc", wb_src, 0);
        chk("addi_w_aluop", alu_op, 1);
        chk("addi_w_alusrc", alu_src, 1);
        chk("addi_w_cnt", instr_count, 0);
        go();
        chk("addi_next", state, 1);
        chk("addi_cnt", instr_count, 1);

        // LW with ack in the fourth MEM cycle
        fetch_to_exec(3'b101);
        chk("lw_e_aluop", alu_op, 5);
        chk("lw_e_alusrc", alu_src, 1);
        go();
        for (int i = 0; i < 3; i++) begin
            chk("lw_m_state", state, 4);
            chk("lw_m_req", mem_req, 1);
            chk("lw_m_sel", mem_sel, 1);
            chk("lw_m_we", mem_we, 0);
            go();
        end
        mem_ack = 1'b1; #1;
        chk("lw_m4_state", state, 4);
        chk("lw_m4_sel", mem_sel, 1);
        go(); mem_ack = 1'b0; #1;
        chk("lw_w_state", state, 5);
        chk("lw_w_wbsrc", wb_src, 1);
        chk("lw_w_regwe", reg_we, 1);
        go();
        chk("lw_next", state, 1);
        chk("lw_cnt", instr_count, 2);

        // BNE taken
        fetch_to_exec(3'b110);
        alu_zero = 1'b0; #1;
        chk("bne0_state", state, 3);
        chk("bne0_pcwe", pc_we, 1);
        chk("bne0_pcsrc", pc_src, 1);
        chk("bne0_aluop", alu_op, 6);
        chk("bne0_alusrc", alu_src, 0);
        go();
        chk("bne0_next", state, 1);
        chk("bne0_cnt", instr_count, 3);

        // BNE not taken
        fetch_to_exec(3'b110);
        alu_zero = 1'b1; #1;
        chk("bne1_pcwe", pc_we, 0);
        chk("bne1_regwe", reg_we, 0);
        go();
        chk("bne1_next", state, 1);
        chk("bne1_cnt", instr_count, 4);
        alu_zero = 1'b0;

        // JALR
        fetch_to_exec(3'b111);
        chk("jalr_regwe", reg_we, 1);
        chk("jalr_wbsrc", wb_src, 2);
        chk("jalr_pcwe", pc_we, 1);
        chk("jalr_pcsrc", pc_src, 2);
        go();
        chk("jalr_next", state, 1);
        chk("jalr_cnt", instr_count, 5);

        // FETCH acked on the last allowed cycle, then SW
        opcode = 3'b100; mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("fw_state", state, 1);
            chk("fw_req", mem_req, 1);
            chk("fw_irwe", ir_we, 0);
            go();
        end
        mem_ack = 1'b1; #1;
        chk("fw_last_irwe", ir_we, 1);
        go(); mem_ack = 1'b0; #1;
        chk("fw_decode", state, 2);
        go();
        chk("sw_e_aluop", alu_op, 4);
        chk("sw_e_alusrc", alu_src, 1);
        go();
        chk("sw_m_state", state, 4);
        chk("sw_m_we", mem_we, 1);
        chk("sw_m_sel", mem_sel, 1);
        mem_ack = 1'b1;
        go(); mem_ack = 1'b0; #1;
        chk("sw_next", state, 1);
        chk("sw_cnt", instr_count, 6);

        // run dropped during EXEC completes the instruction
        fetch_to_exec(3'b000);
        run = 1'b0; #1;
        chk("rd_e_aluop", alu_op, 0);
        go();
        chk("rd_w_state", state, 5);
        go();
        chk("rd_idle", state, 0);
        chk("rd_cnt", instr_count, 7);
        go();
        chk("rd_idle_hold", state, 0);
        chk("rd_idle_req", mem_req, 0);

        // reset during SW MEM
        run = 1'b1;
        go();
        fetch_to_exec(3'b100);
        go();
        chk("rsw_m_we", mem_we, 1);
        rst = 1'b1;
        go();
        chk("rsw_state", state, 0);
        chk("rsw_req", mem_req, 0);
        chk("rsw_we", mem_we, 0);
        chk("rsw_cnt", instr_count, 0);
        rst = 1'b0;

        // FETCH timeout
        go();
        chk("to_fetch", state, 1);
        mem_ack = 1'b0;
        repeat (4) go();
        chk("to_state", state, 7);
        chk("to_buserr", bus_err, 1);
        chk("to_req", mem_req, 0);
        mem_ack = 1'b1;
        repeat (3) go();
        chk("to_hold", state, 7);
        chk("to_hold_be", bus_err, 1);
        chk("to_hold_irwe", ir_we, 0);
        chk("to_hold_pcwe", pc_we, 0);
        mem_ack = 1'b0;
        rst = 1'b1;
        go();
        chk("to_rst_state", state, 0);
        chk("to_rst_be", bus_err, 0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mips16_seq_ctrl.md
# mips16_seq_ctrl

Multi-cycle sequencer for the 16-bit MIPS-style CPU datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives all datapath strobes: PC/IR/register-file write enables, ALU op, operand select, writeback mux, and a shared instruction/data memory request. Memory latency is variable, and a watchdog traps a memory that never acknowledges. It replaces the single-cycle, one-pass-per-clock control of the existing core.

## Interface
- MEM_TIMEOUT, 15: maximum request cycles per memory access before trapping (≥1).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  allow fetching of new instructions.
- opcode  in  3  IR[15:13]; valid from DECODE onward.
- alu_zero  in  1  ALU zero flag (used by BNE).
- mem_ack  in  1  memory completion, one cycle.
- ir_we  out  1  load IR from memory read data.
- pc_we  out  1  load PC.
- pc_src  out  2  00 PC+1, 01 PC+sext(IR[6:0]), 10 reg B.
- reg_we  out  1  register-file write to IR[12:10].
- wb_src  out  2  00 ALU, 01 memory data, 10 PC (link).
- alu_op  out  4  0000 ADD, 0001 ADDI, 0010 NAND, 0011 LUI, 0100 SW addr, 0101 LW addr, 0110 SUB/compare.
- alu_src  out  1  0 reg C, 1 immediate.
- mem_req  out  1  memory access request.
- mem_we  out  1  write (SW only).
- mem_sel  out  1  0 instruction address (PC), 1 data address (ALU).
- state  out  3  current state, for debug.
- instr_count  out  CNT_W  retired instructions; wraps modulo 2^CNT_W.
- bus_err  out  1  sticky memory timeout flag.

## Operation
- Opcodes: 000 ADD, 001 ADDI, 010 NAND, 011 LUI, 100 SW, 101 LW, 110 BNE, 111 JALR.
- State encoding: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, ERROR 7.
- Registers: state, wait counter, instr_count, bus_err.
- Strobes are combinational from state, opcode, mem_ack and alu_zero. Every strobe is 0 unless listed for a state below.

State behaviour:
- **IDLE**: when run=1, go to FETCH.
- **FETCH**:
  - mem_req=1, mem_sel=0.
  - On mem_ack: ir_we=1, pc_we=1, pc_src=00, then go to DECODE.
- **DECODE**: register read only, no strobes; go to EXEC.
- **EXEC**: alu_op per opcode; alu_src=1 for ADDI, LUI, SW, LW.
  - ADD, ADDI, NAND, LUI: go to WB.
  - SW, LW: go to MEM.
  - BNE: alu_op=0110, alu_src=0. If alu_zero=0, assert pc_we with pc_src=01. Instruction retires.
  - JALR: reg_we=1, wb_src=10, pc_we=1, pc_src=10. Instruction retires. The link value is the already-incremented PC.
- **MEM**: mem_req=1, mem_sel=1, mem_we=(opcode==100); alu_op and alu_src held from EXEC.
  - On mem_ack: SW retires, LW goes to WB.
- **WB**: reg_we=1; wb_src=01 for LW, otherwise 00; alu_op and alu_src held.
  - Instruction retires.

Retire and run control:
- On a retire cycle, instr_count increments.
- Next state after a retire is FETCH if run=1, otherwise IDLE.
- run is sampled only in IDLE and on retire cycles. Deasserting run mid-instruction completes that instruction.

Memory watchdog:
- The wait counter clears on entry to FETCH or MEM.
- It increments on each request cycle without mem_ack.
- mem_ack low in the cycle where the counter equals MEM_TIMEOUT−1 → go to ERROR and set bus_err.
- mem_ack high in that same cycle is accepted normally.
- mem_ack outside FETCH or MEM is ignored.

ERROR:
- All strobes 0; bus_err=1.
- Held until rst.

## Timing
- Reset: state=IDLE, instr_count=0, bus_err=0, wait counter=0. All strobes are therefore 0 and alu_op=0000.
- rst sampled high mid-operation abandons the instruction. mem_req is low from the following cycle; no partial write strobe is issued after the reset edge.
- Latency, with mem_ack in the first request cycle: ALU op 4 cycles, LW 5, SW 4, BNE 3, JALR 3.
- Each extra wait cycle adds 1 to the latency.
- Back-to-back instructions with run=1 leave no idle gap: the cycle after a retire is FETCH.
- pc_we and ir_we pulse for exactly one cycle per event.

## Structure
- Package mips16_pkg holds:
  - opcode_t enum.
  - alu_op_t constants.
  - state_t enum.
  - pc_src and wb_src encodings.
  - The datapath shares the same package.
- One sub-module, mem_wait_timer: clear, count-enable and expired output, parameterized by MEM_TIMEOUT.
- The FSM and output decode stay in mips16_seq_ctrl.

## Test plan
- **ADDI sequence**: run=1, opcode=001, mem_ack in the first FETCH cycle → states 1,2,3,5; alu_op=0001, alu_src=1 in EXEC and WB; reg_we=1 in WB; instr_count=1 after 4 cycles.
- **LW with slow memory**: opcode=101, MEM ack after 3 wait cycles → mem_sel=1, mem_we=0 for 4 cycles, then WB with wb_src=01; 8 cycles total.
- **BNE both ways**:
  - alu_zero=0 → pc_we=1, pc_src=01 in EXEC.
  - alu_zero=1 → pc_we=0.
  - Both retire in 3 cycles.
- **JALR**: opcode=111 → in EXEC, reg_we=1, wb_src=10, pc_we=1, pc_src=10, all in one cycle.
- **Timeout**, MEM_TIMEOUT=4:
  - No ack for 4 FETCH cycles → state=7, bus_err=1, mem_req=0; stays until rst.
  - Ack in the 4th cycle instead → DECODE.
- **Reset and run control**:
  - rst asserted in MEM of SW → next cycle state=0, mem_req=0, instr_count=0.
  - run dropped during EXEC → instruction retires, then IDLE.
